vga_fade: RTL and testbench

//  Brightness fader between bar_gen and the VGA pins. Takes RGB, HSYNC, VSYNC and DISPLAY.

---
 rtl/vga_fade.sv | 144 ++++++++++++++
 tb/tb_vga_fade.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_fade.sv
// vga_fade: brightness fader between the bar generator and the VGA pins.
// Scales RGB by a frame-synchronous fade level; sync/DISPLAY delayed to match the RGB latency.
// Ports: pixel_clk, reset (async, active-low); in_R/G/B, in_HSYNC, in_VSYNC, in_DISPLAY from the
// bar generator; fade_in/fade_out command pulses; R/G/B, HSYNC, VSYNC, DISPLAY to the pins
// (2-cycle latency); busy while fading; done pulse at the end of a fade; current level.
module vga_fade #(
    parameter int RGB_WIDTH       = 8,
    parameter int LEVEL_WIDTH     = 4,
    parameter int FRAMES_PER_STEP = 2,
    parameter bit HSYNC_POL       = 1'b0,
    parameter bit VSYNC_POL       = 1'b0,
    parameter bit START_ON        = 1'b1
) (
    input  logic                   pixel_clk,
    input  logic                   reset,
    input  logic [RGB_WIDTH-1:0]   in_R,
    input  logic [RGB_WIDTH-1:0]   in_G,
    input  logic [RGB_WIDTH-1:0]   in_B,
    input  logic                   in_HSYNC,
    input  logic                   in_VSYNC,
    input  logic                   in_DISPLAY,
    input  logic                   fade_in,
    input  logic                   fade_out,
    output logic [RGB_WIDTH-1:0]   R,
    output logic [RGB_WIDTH-1:0]   G,
    output logic [RGB_WIDTH-1:0]   B,
    output logic                   HSYNC,
    output logic                   VSYNC,
    output logic                   DISPLAY,
    output logic                   busy,
    output logic                   done,
    output logic [LEVEL_WIDTH:0]   level
);
    localparam int PW = RGB_WIDTH + LEVEL_WIDTH + 1;
    localparam int CW = FRAMES_PER_STEP > 1 ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [LEVEL_WIDTH:0] LVL_FULL = (LEVEL_WIDTH + 1)'(1 << LEVEL_WIDTH);
    localparam logic [LEVEL_WIDTH:0] LVL_ONE  = (LEVEL_WIDTH + 1)'(1);
    localparam logic [CW-1:0]        CNT_LAST = CW'(FRAMES_PER_STEP - 1);

    typedef enum logic [1:0] {OFF, FADE_IN, ON, FADE_OUT} state_t;

    function automatic logic [RGB_WIDTH-1:0] scale(input logic [RGB_WIDTH-1:0] c, input logic [LEVEL_WIDTH:0] l);
        return RGB_WIDTH'((PW'(c) * PW'(l)) >> LEVEL_WIDTH);
    endfunction

    logic [RGB_WIDTH-1:0] r_s1_q, g_s1_q, b_s1_q, r_q, g_q, b_q, r_d, g_d, b_d;
    logic                 hs_s1_q, vs_s1_q, de_s1_q, vs_prev_q, hs_q, vs_q, de_q;
    logic                 tick, done_q, done_d;
    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [LEVEL_WIDTH:0] level_q, level_d;

    // Tick on the registered VSYNC entering its active level: always inside vertical blanking.
    assign tick = (vs_s1_q == VSYNC_POL) && (vs_prev_q != VSYNC_POL);

    always_comb begin
        r_d     = de_s1_q ? scale(r_s1_q, level_q) : '0;
        g_d     = de_s1_q ? scale(g_s1_q, level_q) : '0;
        b_d     = de_s1_q ? scale(b_s1_q, level_q) : '0;
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        done_d  = 1'b0;
        // fade_out has priority; a command matching the current direction/end state is ignored
        if (fade_out && (state_q == ON || state_q == FADE_IN)) begin
            state_d = FADE_OUT;
            cnt_d   = '0;
        end else if (!fade_out && fade_in && (state_q == OFF || state_q == FADE_OUT)) begin
            state_d = FADE_IN;
            cnt_d   = '0;
        end
        // A tick in the same cycle as a command counts in the new state's fresh counter
        if (tick && (state_d == FADE_IN || state_d == FADE_OUT)) begin
            if (cnt_d == CNT_LAST) begin
                cnt_d = '0;
                if (state_d == FADE_IN) begin
                    level_d = level_d == LVL_FULL ? level_d : level_d + LVL_ONE;
                    if (level_d == LVL_FULL) begin
                        state_d = ON;
                        done_d  = 1'b1;
                    end
                end else begin
                    level_d = level_d == '0 ? level_d : level_d - LVL_ONE;
                    if (level_d == '0) begin
                        state_d = OFF;
                        done_d  = 1'b1;
                    end
                end
            end else begin
                cnt_d = cnt_d + CW'(1);
            end
        end
    end

    always_ff @(posedge pixel_clk or negedge reset) begin
        if (!reset) begin
            r_s1_q    <= '0;
            g_s1_q    <= '0;
            b_s1_q    <= '0;
            hs_s1_q   <= ~HSYNC_POL;
            vs_s1_q   <= ~VSYNC_POL;
            de_s1_q   <= 1'b0;
            vs_prev_q <= ~VSYNC_POL;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            hs_q      <= ~HSYNC_POL;
            vs_q      <= ~VSYNC_POL;
            de_q      <= 1'b0;
            state_q   <= START_ON ? ON : OFF;
            level_q   <= START_ON ? LVL_FULL : '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            r_s1_q    <= in_R;
            g_s1_q    <= in_G;
            b_s1_q    <= in_B;
            hs_s1_q   <= in_HSYNC;
            vs_s1_q   <= in_VSYNC;
            de_s1_q   <= in_DISPLAY;
            vs_prev_q <= vs_s1_q;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            hs_q      <= hs_s1_q;
            vs_q      <= vs_s1_q;
            de_q      <= de_s1_q;
            state_q   <= state_d;
            level_q   <= level_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
        end
    end

    assign R       = r_q;
    assign G       = g_q;
    assign B       = b_q;
    assign HSYNC   = hs_q;
    assign VSYNC   = vs_q;
    assign DISPLAY = de_q;
    assign busy    = state_q == FADE_IN || state_q == FADE_OUT;
    assign done    = done_q;
    assign level   = level_q;
endmodule

// File: tb/tb_vga_fade.sv
// tb_vga_fade: directed + randomized bench for vga_fade with a cycle-level reference model.
module tb_vga_fade;
    localparam int RW = 8, LW = 2, FULL = 4;
    localparam int OFF = 0, FIN = 1, ON = 2, FOUT = 3;

    logic pixel_clk = 1'b0, reset = 1'b0;
    logic [RW-1:0] in_R = '0, in_G = '0, in_B = '0;
    logic in_HSYNC = 1'b1, in_VSYNC = 1'b1, in_DISPLAY = 1'b0, fade_in = 1'b0, fade_out = 1'b0;
    logic [RW-1:0] r_o[2], g_o[2], b_o[2];
    logic hs_o[2], vs_o[2], de_o[2], busy_o[2], done_o[2];
    logic [LW:0] lvl_o[2];

    int checks = 0, errors = 0, done_seen = 0;
    int fps[2] = '{1, 3};
    int start_on[2] = '{1, 0};
    int m_st[2], m_lvl[2], m_cnt[2], m_done[2];
    int s_r, s_g, s_b, s_hs, s_vs, s_de, p_vs;
    int e_r[2], e_g[2], e_b[2], e_hs, e_vs, e_de;

    always #5 pixel_clk = ~pixel_clk;

    vga_fade #(.RGB_WIDTH(RW), .LEVEL_WIDTH(LW), .FRAMES_PER_STEP(1), .HSYNC_POL(1'b0),
               .VSYNC_POL(1'b0), .START_ON(1'b1)) dut (
        .pixel_clk(pixel_clk), .reset(reset), .in_R(in_R), .in_G(in_G), .in_B(in_B),
        .in_HSYNC(in_HSYNC), .in_VSYNC(in_VSYNC), .in_DISPLAY(in_DISPLAY),
        .fade_in(fade_in), .fade_out(fade_out), .R(r_o[0]), .G(g_o[0]), .B(b_o[0]),
        .HSYNC(hs_o[0]), .VSYNC(vs_o[0]), .DISPLAY(de_o[0]), .busy(busy_o[0]),
        .done(done_o[0]), .level(lvl_o[0]));

    vga_fade #(.RGB_WIDTH(RW), .LEVEL_WIDTH(LW), .FRAMES_PER_STEP(3), .HSYNC_POL(1'b0),
               .VSYNC_POL(1'b0), .START_ON(1'b0)) dut3 (
        .pixel_clk(pixel_clk), .reset(reset), .in_R(in_R), .in_G(in_G), .in_B(in_B),
        .in_HSYNC(in_HSYNC), .in_VSYNC(in_VSYNC), .in_DISPLAY(in_DISPLAY),
        .fade_in(fade_in), .fade_out(fade_out), .R(r_o[1]), .G(g_o[1]), .B(b_o[1]),
        .HSYNC(hs_o[1]), .VSYNC(vs_o[1]), .DISPLAY(de_o[1]), .busy(busy_o[1]),
        .done(done_o[1]), .level(lvl_o[1]));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        s_r = 0; s_g = 0; s_b = 0; s_hs = 1; s_vs = 1; s_de = 0; p_vs = 1;
        e_hs = 1; e_vs = 1; e_de = 0;
        for (int i = 0; i < 2; i++) begin
            e_r[i] = 0; e_g[i] = 0; e_b[i] = 0;
            m_st[i] = start_on[i] ? ON : OFF;
            m_lvl[i] = start_on[i] ? FULL : 0;
            m_cnt[i] = 0; m_done[i] = 0;
        end
    endtask

    // Effect of one rising edge: outputs from last cycle's samples at the old level, then fade rules.
    task automatic model_edge();
        bit tk = (s_vs == 0) && (p_vs != 0);
        e_hs = s_hs; e_vs = s_vs; e_de = s_de;
        for (int i = 0; i < 2; i++) begin
            e_r[i] = s_de ? s_r * m_lvl[i] / FULL : 0;
            e_g[i] = s_de ? s_g * m_lvl[i] / FULL : 0;
            e_b[i] = s_de ? s_b * m_lvl[i] / FULL : 0;
            m_done[i] = 0;
            if (fade_out && (m_st[i] == ON || m_st[i] == FIN)) begin
                m_st[i] = FOUT; m_cnt[i] = 0;
            end else if (fade_in && !fade_out && (m_st[i] == OFF || m_st[i] == FOUT)) begin
                m_st[i] = FIN; m_cnt[i] = 0;
            end
            if (tk && (m_st[i] == FIN || m_st[i] == FOUT)) begin
                m_cnt[i]++;
                if (m_cnt[i] == fps[i]) begin
                    m_cnt[i] = 0;
                    if (m_st[i] == FIN) begin
                        if (m_lvl[i] < FULL) m_lvl[i]++;
                        if (m_lvl[i] == FULL) begin m_st[i] = ON; m_done[i] = 1; end
                    end else begin
                        if (m_lvl[i] > 0) m_lvl[i]--;
                        if (m_lvl[i] == 0) begin m_st[i] = OFF; m_done[i] = 1; end
                    end
                end
            end
        end
        p_vs = s_vs;
        s_r = in_R; s_g = in_G; s_b = in_B; s_hs = in_HSYNC; s_vs = in_VSYNC; s_de = in_DISPLAY;
    endtask

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("R%0d", i), r_o[i], e_r[i]);
            check($sformatf("G%0d", i), g_o[i], e_g[i]);
            check($sformatf("B%0d", i), b_o[i], e_b[i]);
            check($sformatf("HSYNC%0d", i), hs_o[i], e_hs);
            check($sformatf("VSYNC%0d", i), vs_o[i], e_vs);
            check($sformatf("DISPLAY%0d", i), de_o[i], e_de);
            check($sformatf("level%0d", i), lvl_o[i], m_lvl[i]);
            check($sformatf("busy%0d", i), busy_o[i], (m_st[i] == FIN || m_st[i] == FOUT) ? 1 : 0);
            check($sformatf("done%0d", i), done_o[i], m_done[i]);
        end
    endtask

    task automatic cyc();
        @(posedge pixel_clk);
        model_edge();
        @(negedge pixel_clk);
        check_all();
        done_seen += int'(done_o[0]);
        fade_in = 1'b0;
        fade_out = 1'b0;
    endtask

    task automatic rand_px();
        in_R = RW'($urandom); in_G = RW'($urandom); in_B = RW'($urandom);
        in_HSYNC = 1'($urandom); in_DISPLAY = 1'($urandom);
    endtask

    task automatic frame();
        for (int k = 0; k < 6; k++) begin
            rand_px();
            in_VSYNC = (k == 2 || k == 3) ? 1'b0 : 1'b1;
            cyc();
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge pixel_clk);
        check("rst_R", r_o[0], 0);
        check("rst_HSYNC", hs_o[0], 1);
        check("rst_VSYNC", vs_o[0], 1);
        check("rst_DISPLAY", de_o[0], 0);
        check("rst_busy", busy_o[0], 0);
        check("rst_level_on", lvl_o[0], FULL);
        check("rst_level_off", lvl_o[1], 0);
        reset = 1'b1;
        // latency
        in_R = 8'hFF; in_DISPLAY = 1'b1; in_HSYNC = 1'b0;
        cyc();
        in_HSYNC = 1'b1;
        cyc();
        check("lat_R", r_o[0], 8'hFF);
        check("lat_DISPLAY", de_o[0], 1);
        check("lat_HSYNC", hs_o[0], 0);
        repeat (10) begin rand_px(); cyc(); end
        // fade out, scaling at level 2
        done_seen = 0;
        fade_out = 1'b1;
        cyc();
        check("fo_busy", busy_o[0], 1);
        frame(); check("fo_lvl3", lvl_o[0], 3);
        frame(); check("fo_lvl2", lvl_o[0], 2);
        in_R = 8'hC8; in_DISPLAY = 1'b1;
        cyc(); cyc();
        check("scale_R", r_o[0], 8'h64);
        in_DISPLAY = 1'b0;
        cyc(); cyc();
        check("blank_R", r_o[0], 0);
        frame(); check("fo_lvl1", lvl_o[0], 1);
        check("fo_busy_mid", busy_o[0], 1);
        frame(); check("fo_lvl0", lvl_o[0], 0);
        check("fo_idle", busy_o[0], 0);
        check("fo_done_once", done_seen, 1);
        in_R = 8'hFF; in_DISPLAY = 1'b1;
        cyc(); cyc();
        check("off_R", r_o[0], 0);
        // fade back in, then reversal at level 2
        fade_in = 1'b1;
        cyc();
        repeat (4) frame();
        check("fi_lvl4", lvl_o[0], FULL);
        fade_out = 1'b1;
        cyc();
        frame(); frame();
        check("rev_lvl2", lvl_o[0], 2);
        fade_in = 1'b1;
        cyc();
        frame(); check("rev_lvl3", lvl_o[0], 3);
        frame(); check("rev_lvl4", lvl_o[0], 4);
        check("rev_on", busy_o[0], 0);
        fade_in = 1'b1; fade_out = 1'b1;
        cyc();
        check("both_fadeout", busy_o[0], 1);
        fade_in = 1'b1;
        cyc();
        frame();
        check("sat_on", busy_o[0], 0);
        check("sat_lvl", lvl_o[0], FULL);
        fade_in = 1'b1;
        cyc();
        check("fi_in_on_ignored", busy_o[0], 0);
        // FRAMES_PER_STEP=3 instance
        @(negedge pixel_clk); reset = 1'b0; model_reset();
        @(negedge pixel_clk); reset = 1'b1;
        fade_in = 1'b1;
        cyc();
        for (int f = 1; f <= 12; f++) begin
            frame();
            check($sformatf("fps3_lvl_f%0d", f), lvl_o[1], f / 3);
        end
        check("fps3_on", busy_o[1], 0);
        // asynchronous reset mid-fade
        fade_out = 1'b1;
        cyc();
        frame(); frame();
        check("pre_rst_lvl", lvl_o[0], 2);
        @(posedge pixel_clk);
        #2 reset = 1'b0;
        #1;
        model_reset();
        check("arst_R", r_o[0], 0);
        check("arst_HSYNC", hs_o[0], 1);
        check("arst_VSYNC", vs_o[0], 1);
        check("arst_DISPLAY", de_o[0], 0);
        check("arst_busy", busy_o[0], 0);
        check("arst_level", lvl_o[0], FULL);
        @(negedge pixel_clk);
        reset = 1'b1;
        in_VSYNC = 1'b1;
        repeat (4) cyc();
        // random commands across frames
        for (int n = 0; n < 30; n++) begin
            fade_in = 1'($urandom);
            fade_out = 1'($urandom_range(0, 3) == 0);
            frame();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
